// File: rtl/sc_spi_arb.sv
// Round-robin arbiter sharing one SPI engine among NUM_OF_REQ requesters.
// Grant is held across CS-extended chains; start timeout returns an error pulse.
module sc_spi_arb #(
  parameter int NUM_OF_REQ   = 4,
  parameter int CSSEL_W      = 5,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                          i_sysclk,
  input  logic                          i_sysrst,
  input  logic [NUM_OF_REQ-1:0]         i_req,
  input  logic [NUM_OF_REQ*CSSEL_W-1:0] i_req_cssel,
  input  logic [NUM_OF_REQ-1:0]         i_req_csextend,
  output logic [NUM_OF_REQ-1:0]         o_gnt,
  output logic [NUM_OF_REQ-1:0]         o_done,
  output logic [NUM_OF_REQ-1:0]         o_err,
  output logic                          o_txstart,
  output logic [CSSEL_W-1:0]            o_cssel,
  output logic                          o_csextend,
  input  logic                          i_spibusy,
  input  logic                          i_spicomplete
);

  localparam int IW = (NUM_OF_REQ > 1) ? $clog2(NUM_OF_REQ) : 1;
  localparam logic [NUM_OF_REQ-1:0] ONE = NUM_OF_REQ'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_CMPL,
    S_LOCK
  } state_t;

  state_t                  r_state;
  logic [IW-1:0]           r_ptr;
  logic [IW-1:0]           r_gidx;
  logic [15:0]             r_cnt;
  logic [NUM_OF_REQ-1:0]   r_gnt;
  logic [NUM_OF_REQ-1:0]   r_done;
  logic [NUM_OF_REQ-1:0]   r_err;
  logic                    r_txstart;
  logic [CSSEL_W-1:0]      r_cssel;
  logic                    r_csextend;

  logic [CSSEL_W-1:0]      w_cssel_arr [NUM_OF_REQ];
  logic [IW-1:0]           w_idx;
  logic [IW-1:0]           w_win;
  logic                    w_win_vld;
  logic [IW-1:0]           w_gnext;
  logic [16:0]             w_cnt_nxt;
  logic                    w_cmpl;
  logic                    w_timeout;

  always_comb begin
    for (int i = 0; i < NUM_OF_REQ; i++) begin
      w_cssel_arr[i] = i_req_cssel[i*CSSEL_W +: CSSEL_W];
    end
  end

  // Walk downward so the candidate closest to the pointer is written last and wins.
  always_comb begin
    w_idx     = '0;
    w_win     = '0;
    w_win_vld = 1'b0;
    for (int k = NUM_OF_REQ - 1; k >= 0; k--) begin
      w_idx = IW'((int'(r_ptr) + k) % NUM_OF_REQ);
      if (i_req[w_idx]) begin
        w_win     = w_idx;
        w_win_vld = 1'b1;
      end
    end
  end

  assign w_gnext   = (r_gidx == IW'(NUM_OF_REQ - 1)) ? '0 : r_gidx + IW'(1);
  assign w_cnt_nxt = {1'b0, r_cnt} + 17'd1;
  assign w_timeout = (w_cnt_nxt >= 17'(BUSY_TIMEOUT - 1));
  assign w_cmpl    = i_spicomplete && ((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_CMPL));

  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_gidx     <= '0;
      r_cnt      <= '0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_err      <= '0;
      r_txstart  <= 1'b0;
      r_cssel    <= '0;
      r_csextend <= 1'b0;
    end else begin
      r_done    <= '0;
      r_err     <= '0;
      r_txstart <= 1'b0;
      if (w_cmpl) begin
        r_done <= ONE << r_gidx;
        if (r_csextend) begin
          r_state <= S_LOCK;
        end else begin
          r_gnt   <= '0;
          r_ptr   <= w_gnext;
          r_state <= S_IDLE;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_win_vld && !i_spibusy) begin
              r_gidx     <= w_win;
              r_gnt      <= ONE << w_win;
              r_cssel    <= w_cssel_arr[w_win];
              r_csextend <= i_req_csextend[w_win];
              r_txstart  <= 1'b1;
              r_state    <= S_START;
            end
          end
          S_START: begin
            r_cnt   <= '0;
            r_state <= S_WAIT_BUSY;
          end
          S_WAIT_BUSY: begin
            if (i_spibusy) begin
              r_state <= S_WAIT_CMPL;
            end else if (w_timeout) begin
              r_err      <= ONE << r_gidx;
              r_gnt      <= '0;
              r_csextend <= 1'b0;
              r_ptr      <= w_gnext;
              r_state    <= S_IDLE;
            end else begin
              r_cnt <= w_cnt_nxt[15:0];
            end
          end
          S_WAIT_CMPL: begin
            r_state <= S_WAIT_CMPL;
          end
          S_LOCK: begin
            // Skip the DONE cycle so the requester has a cycle to drop REQ.
            if (r_done == '0) begin
              if (i_req[r_gidx]) begin
                r_csextend <= i_req_csextend[r_gidx];
                r_txstart  <= 1'b1;
                r_state    <= S_START;
              end else begin
                r_gnt      <= '0;
                r_csextend <= 1'b0;
                r_ptr      <= w_gnext;
                r_state    <= S_IDLE;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_gnt      = r_gnt;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_txstart  = r_txstart;
  assign o_cssel    = r_cssel;
  assign o_csextend = r_csextend;

endmodule

// File: tb/tb_sc_spi_arb.sv
// Directed bench for sc_spi_arb: grant latency, round-robin, CS chains, timeout, blocking, reset.
module tb_sc_spi_arb;

  localparam int N  = 4;
  localparam int CW = 5;
  localparam int BT = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N*CW-1:0] req_cssel = '0;
  logic [N-1:0]  req_csext = '0;
  logic          busy = 1'b0;
  logic          cmpl = 1'b0;
  logic [N-1:0]  gnt, done, err;
  logic          txstart;
  logic [CW-1:0] cssel;
  logic          csext;

  int n_assert = 0;
  int n_fail   = 0;

  sc_spi_arb #(.NUM_OF_REQ(N), .CSSEL_W(CW), .BUSY_TIMEOUT(BT)) dut (
    .i_sysclk       (clk),
    .i_sysrst       (rst),
    .i_req          (req),
    .i_req_cssel    (req_cssel),
    .i_req_csextend (req_csext),
    .o_gnt          (gnt),
    .o_done         (done),
    .o_err          (err),
    .o_txstart      (txstart),
    .o_cssel        (cssel),
    .o_csextend     (csext),
    .i_spibusy      (busy),
    .i_spicomplete  (cmpl)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req = '0; req_csext = '0; busy = 1'b0; cmpl = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Returns at the negedge of the cycle where TXSTART is high (or after the budget expires).
  task automatic wait_tx(input string tag, input int maxc);
    int n;
    n = 0;
    while (txstart !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(txstart), 32'd1);
  endtask

  // Engine: busy rises bdly cycles after TXSTART, completion cdly cycles later; ends in DONE cycle.
  task automatic engine(input int bdly, input int cdly);
    repeat (bdly) @(posedge clk);
    #1 busy = 1'b1;
    repeat (cdly) @(posedge clk);
    #1 busy = 1'b0; cmpl = 1'b1;
    @(posedge clk);
    #1 cmpl = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit seen;

    // Reset state
    do_reset();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done_err", 32'(done | err), 32'd0);
    check("rst_txstart", 32'(txstart), 32'd0);
    check("rst_cssel", 32'(cssel), 32'd0);
    check("rst_csext", 32'(csext), 32'd0);

    // Single requester: grant and TXSTART one cycle after REQ
    req_cssel[0*CW +: CW] = 5'd3;
    req = 4'b0001;
    @(negedge clk);
    check("single_gnt", 32'(gnt), 32'h1);
    check("single_txstart", 32'(txstart), 32'd1);
    check("single_cssel", 32'(cssel), 32'd3);
    req = 4'b0000;
    @(negedge clk);
    check("single_txstart_off", 32'(txstart), 32'd0);
    engine(1, 40);
    check("single_done", 32'(done), 32'h1);
    check("single_gnt_clr", 32'(gnt), 32'h0);
    @(negedge clk);
    check("single_done_pulse", 32'(done), 32'h0);
    check("single_idle", 32'(gnt | txstart), 32'h0);

    // Round-robin with all requesting
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_tx($sformatf("rr_tx%0d", k), 10);
      check($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(1 << (k % 4)));
      engine(2, 6);
      check($sformatf("rr_done%0d", k), 32'(done), 32'(1 << (k % 4)));
    end

    // CS-extend chain on requester 2
    do_reset();
    req_cssel[2*CW +: CW] = 5'd9;
    req_cssel[3*CW +: CW] = 5'd6;
    req_csext = 4'b0100;
    req = 4'b0100;
    wait_tx("ch_tx1", 5);
    check("ch_gnt1", 32'(gnt), 32'h4);
    check("ch_csext1", 32'(csext), 32'd1);
    check("ch_cssel1", 32'(cssel), 32'd9);
    req = 4'b1111;
    req_cssel[2*CW +: CW] = 5'd5;
    engine(2, 5);
    check("ch_done1", 32'(done), 32'h4);
    check("ch_hold1", 32'(gnt), 32'h4);
    wait_tx("ch_tx2", 5);
    check("ch_gnt2", 32'(gnt), 32'h4);
    check("ch_csext2", 32'(csext), 32'd1);
    req_csext = 4'b0000;
    engine(2, 5);
    check("ch_done2", 32'(done), 32'h4);
    wait_tx("ch_tx3", 5);
    check("ch_gnt3", 32'(gnt), 32'h4);
    check("ch_csext3", 32'(csext), 32'd0);
    check("ch_cssel3", 32'(cssel), 32'd9);
    engine(2, 5);
    check("ch_done3", 32'(done), 32'h4);
    check("ch_gnt_clr", 32'(gnt), 32'h0);
    wait_tx("ch_next_tx", 5);
    check("ch_next_gnt", 32'(gnt), 32'h8);
    check("ch_next_cssel", 32'(cssel), 32'd6);

    // Start timeout: engine never answers
    do_reset();
    req = 4'b0010;
    wait_tx("to_tx", 5);
    repeat (BT - 1) @(negedge clk);
    check("to_early", 32'(err), 32'h0);
    @(negedge clk);
    check("to_err", 32'(err), 32'h2);
    check("to_gnt", 32'(gnt), 32'h0);
    req = 4'b0000;
    @(negedge clk);
    check("to_err_pulse", 32'(err), 32'h0);
    check("to_idle", 32'(gnt | txstart), 32'h0);

    // Blocked start while engine busy in IDLE
    busy = 1'b1;
    req = 4'b0001;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (gnt != '0 || txstart) seen = 1'b1;
    end
    check("blk_nogrant", 32'(seen), 32'd0);
    busy = 1'b0;
    @(negedge clk);
    check("blk_gnt", 32'(gnt), 32'h1);
    check("blk_tx", 32'(txstart), 32'd1);
    req = 4'b0000;
    engine(2, 5);
    check("blk_done", 32'(done), 32'h1);

    // Reset during WAIT_CMPL; pointer is 1 beforehand
    req_csext = 4'b0001;
    req = 4'b0001;
    wait_tx("rm_tx", 5);
    check("rm_csext_pre", 32'(csext), 32'd1);
    req = 4'b0000;
    @(posedge clk); #1 busy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rm_gnt", 32'(gnt), 32'h0);
    check("rm_done_err", 32'(done | err), 32'h0);
    check("rm_tx0", 32'(txstart), 32'd0);
    check("rm_cssel", 32'(cssel), 32'd0);
    check("rm_csext", 32'(csext), 32'd0);
    @(posedge clk); #1 busy = 1'b0; cmpl = 1'b1;
    @(posedge clk); #1 cmpl = 1'b0;
    @(negedge clk);
    check("rm_no_done", 32'(done), 32'h0);
    req_csext = 4'b0000;
    req = 4'b1111;
    wait_tx("rm_tx_after", 5);
    check("rm_gnt_after", 32'(gnt), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_spi_arb.md
Name: sc_spi_arb

Overview:
- Round-robin arbiter and transfer sequencer that shares one SPI protocol engine among NUM_OF_REQ requesters.
- Issues the engine's TXSTART, CSSEL and CSEXTEND controls on behalf of the winning requester.
- Tracks SPIBUSY/SPICOMPLETE and returns per-requester done/error pulses.
- Holds the grant across CS-extended transfer chains so the chip select is never handed to another requester mid-chain.
- Sits in the SYSCLK domain, between the register/DMA requesters and the engine's control inputs.

Parameters:
NUM_OF_REQ, 4, number of requesters (2..8)
CSSEL_W, 5, width of the chip-select index
BUSY_TIMEOUT, 255, SYSCLK cycles to wait for the engine to acknowledge a start (1..65535)

Ports:
SYSCLK  in  1  system clock; all logic on rising edge
SYSRST  in  1  synchronous, active-high reset
REQ  in  NUM_OF_REQ  level request per requester
REQ_CSSEL  in  NUM_OF_REQ*CSSEL_W  packed CS index; requester i uses bits [i*CSSEL_W +: CSSEL_W]
REQ_CSEXTEND  in  NUM_OF_REQ  per-requester keep-CS-asserted flag
GNT  out  NUM_OF_REQ  one-hot grant, held for the whole transfer or chain
DONE  out  NUM_OF_REQ  one-cycle pulse to the granted requester on transfer completion
ERR  out  NUM_OF_REQ  one-cycle pulse to the granted requester on start timeout
TXSTART  out  1  one-cycle start pulse to the engine
CSSEL  out  CSSEL_W  CS index to the engine, registered
CSEXTEND  out  1  CS-extend flag to the engine, registered
SPIBUSY  in  1  engine busy
SPICOMPLETE  in  1  engine completion pulse

Behaviour:
- Reset (SYSRST=1 at a clock edge, including mid-transfer):
  - state=IDLE.
  - GNT, DONE, ERR, TXSTART, CSSEL, CSEXTEND all 0.
  - Round-robin pointer = 0, so requester 0 has highest priority.
  - Timeout counter = 0.
  - An engine transfer already in flight is abandoned; its SPICOMPLETE is ignored in IDLE.
- States: IDLE, START, WAIT_BUSY, WAIT_CMPL, LOCK.
- IDLE:
  - Arbitrates only when |REQ=1 and SPIBUSY=0.
  - Winner = first set REQ bit searching upward from the pointer, wrapping modulo NUM_OF_REQ.
  - At the next edge:
    - GNT=onehot(winner).
    - CSSEL and CSEXTEND latched from the winner's REQ_CSSEL/REQ_CSEXTEND.
    - TXSTART=1.
    - state=START.
  - Latency: REQ seen in IDLE at cycle N gives GNT and TXSTART at N+1.
- START: lasts exactly one cycle with TXSTART=1. Next: TXSTART=0, counter cleared, state=WAIT_BUSY.
- WAIT_BUSY:
  - SPIBUSY=1 -> WAIT_CMPL.
  - SPICOMPLETE=1 -> treated as completion, same action as in WAIT_CMPL. SPICOMPLETE takes priority over SPIBUSY when both are high.
  - Otherwise the counter increments.
  - When the counter reaches BUSY_TIMEOUT-1:
    - ERR[g] pulses for 1 cycle.
    - GNT cleared.
    - CSEXTEND=0.
    - Pointer = g+1.
    - state=IDLE.
- WAIT_CMPL: on SPICOMPLETE=1:
  - DONE[g] pulses for 1 cycle.
  - If latched CSEXTEND=1 -> LOCK, GNT held.
  - Otherwise -> GNT cleared, pointer = g+1 mod NUM_OF_REQ, state=IDLE.
  - SPIBUSY falling without SPICOMPLETE is ignored.
- LOCK (entered the cycle after DONE):
  - Samples REQ[g] only; other requesters are ignored.
  - REQ[g]=1 -> re-latch CSEXTEND from REQ_CSEXTEND[g], keep CSSEL unchanged, TXSTART=1, state=START.
  - REQ[g]=0 -> GNT cleared, CSEXTEND=0, pointer = g+1, state=IDLE.
- Requester handshake:
  - REQ is a level signal, sampled at grant.
  - The requester must drop REQ in the cycle after DONE/ERR unless it wants another transfer.
  - A requester whose REQ stays high after an unlocked DONE re-competes; round-robin prevents it from starving the others.
- DONE and ERR are mutually exclusive. At most one bit of GNT/DONE/ERR is set at any time.
- Changes to REQ_CSSEL/REQ_CSEXTEND after the latch have no effect until the next START.

Test Plan:
- Single requester: REQ=0001, REQ_CSSEL[0]=3. Required: GNT=0001 and TXSTART pulse 1 cycle after REQ, CSSEL=3; engine model raises SPIBUSY 2 cycles later and SPICOMPLETE 40 cycles later; DONE=0001 for 1 cycle, then GNT=0.
- Round-robin: REQ=1111 held, no CSEXTEND. Required: grant order 0,1,2,3,0; each requester gets exactly one DONE per pass.
- CS-extend chain: requester 2, CSEXTEND=1,1,0 over three transfers while REQ=1111. Required: GNT=0100 for all three transfers, 3 TXSTART pulses, CSEXTEND output 1,1,0; grant then passes to requester 3.
- Timeout: REQ=0010 and the engine never asserts SPIBUSY/SPICOMPLETE. Required: ERR=0010 exactly BUSY_TIMEOUT cycles after TXSTART, GNT=0, state back to IDLE.
- Blocked start: SPIBUSY=1 in IDLE with REQ=0001. Required: no GNT and no TXSTART until SPIBUSY=0, then GNT on the next edge.
- Reset mid-transfer: assert SYSRST in WAIT_CMPL. Required: all outputs 0 at the next edge; a later SPICOMPLETE produces no DONE; the next REQ=1111 grants requester 0.
